// File: rtl/seq_frame_monitor.sv
// -----------------------------------------------------------------------------
// seq_frame_monitor
//
// Statistics stage behind the 101 sequence detector. Qualified bits (those
// with bit_valid=1) are grouped into frames of FRAME_LEN bits. For each frame
// the block counts detections, records where the first one fell, and tags
// the frame with the detector mode seen on frame bit 0. When a frame
// completes, its summary is offered through a valid/ready handshake from a
// one-entry holding register. If a completed frame finds that register still
// occupied and not draining, the frame is dropped. A drop sets a sticky
// overflow flag and bumps a saturating drop counter.
//
// Parameters
//   FRAME_LEN  bits per frame (>= 2)
//   CNT_W      width of the per-frame hit counter (saturating)
//   IDX_W      width of the bit-position index (2**IDX_W >= FRAME_LEN)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   bit_valid      a data bit was applied to the detector this cycle
//   detected       detector output, aligned with bit_valid
//   mode           detector mode select, captured as the frame tag
//   rep_ready      consumer accepts the report
//   rep_valid      report available
//   rep_hits       qualified detections in the reported frame
//   rep_first_idx  position of the first detection (0 if none)
//   rep_any        at least one detection in the reported frame
//   rep_mode       mode captured at frame bit 0
//   overflow       sticky: a completed frame was dropped
//   drop_cnt       number of dropped frames, saturating at 255
// -----------------------------------------------------------------------------
module seq_frame_monitor #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             detected,
    input  logic [1:0]       mode,
    input  logic             rep_ready,
    output logic             rep_valid,
    output logic [CNT_W-1:0] rep_hits,
    output logic [IDX_W-1:0] rep_first_idx,
    output logic             rep_any,
    output logic [1:0]       rep_mode,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] HITS_MAX = '1;
    localparam logic [7:0]       DROP_MAX = 8'hFF;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } frame_state_t;

    // ------------------------------------------------------------------
    // Frame FSM and accumulators
    // ------------------------------------------------------------------
    frame_state_t     state_q, state_d;
    logic [IDX_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic             any_q, any_d;
    logic [1:0]       mode_q, mode_d;

    // Accumulator values with the current bit folded in. The completion
    // snapshot uses these, so the last bit's own detection is reported.
    logic [CNT_W-1:0] hits_upd;
    logic [IDX_W-1:0] first_idx_upd;
    logic             any_upd;
    logic [1:0]       tag_cur;
    logic             frame_done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // FRAME_LEN >= 2, so bit 0 can never complete a frame.
                if (bit_valid) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bit_valid && (pos_q == LAST_POS)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic of the frame FSM
    always_comb begin
        // In IDLE the accumulators are already clear, so the same update
        // expressions serve bit 0 and every later bit.
        hits_upd      = (detected && (hits_q != HITS_MAX)) ? hits_q + CNT_W'(1) : hits_q;
        first_idx_upd = (detected && !any_q) ? pos_q : first_idx_q;
        any_upd       = any_q | detected;
        // Bit 0 tags the frame with the live mode; later bits use the capture.
        tag_cur       = (state_q == S_IDLE) ? mode : mode_q;
        frame_done    = bit_valid && (state_q == S_ACCUM) && (pos_q == LAST_POS);

        pos_d       = pos_q;
        hits_d      = hits_q;
        first_idx_d = first_idx_q;
        any_d       = any_q;
        mode_d      = mode_q;

        if (bit_valid) begin
            if (frame_done) begin
                pos_d       = '0;
                hits_d      = '0;
                first_idx_d = '0;
                any_d       = 1'b0;
            end else begin
                pos_d       = pos_q + IDX_W'(1);
                hits_d      = hits_upd;
                first_idx_d = first_idx_upd;
                any_d       = any_upd;
                mode_d      = tag_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q       <= '0;
            hits_q      <= '0;
            first_idx_q <= '0;
            any_q       <= 1'b0;
            mode_q      <= 2'b00;
        end else begin
            pos_q       <= pos_d;
            hits_q      <= hits_d;
            first_idx_q <= first_idx_d;
            any_q       <= any_d;
            mode_q      <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // One-entry report register with drop accounting
    // ------------------------------------------------------------------
    logic             full_q, full_d;
    logic [CNT_W-1:0] rep_hits_q, rep_hits_d;
    logic [IDX_W-1:0] rep_first_q, rep_first_d;
    logic             rep_any_q, rep_any_d;
    logic [1:0]       rep_mode_q, rep_mode_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic xfer;
    logic load;
    logic drop;

    always_comb begin
        xfer = full_q && rep_ready;
        // A transfer in the completion cycle frees the slot for the new frame.
        load = frame_done && (!full_q || xfer);
        drop = frame_done && full_q && !rep_ready;

        full_d      = full_q;
        rep_hits_d  = rep_hits_q;
        rep_first_d = rep_first_q;
        rep_any_d   = rep_any_q;
        rep_mode_d  = rep_mode_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;

        if (load) begin
            full_d      = 1'b1;
            rep_hits_d  = hits_upd;
            rep_first_d = first_idx_upd;
            rep_any_d   = any_upd;
            rep_mode_d  = tag_cur;
        end else if (xfer) begin
            full_d = 1'b0;
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= 1'b0;
            rep_hits_q  <= '0;
            rep_first_q <= '0;
            rep_any_q   <= 1'b0;
            rep_mode_q  <= 2'b00;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            full_q      <= full_d;
            rep_hits_q  <= rep_hits_d;
            rep_first_q <= rep_first_d;
            rep_any_q   <= rep_any_d;
            rep_mode_q  <= rep_mode_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign rep_valid     = full_q;
    assign rep_hits      = rep_hits_q;
    assign rep_first_idx = rep_first_q;
    assign rep_any       = rep_any_q;
    assign rep_mode      = rep_mode_q;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_seq_frame_monitor.sv
// -----------------------------------------------------------------------------
// tb_seq_frame_monitor
//
// Two instances share one stimulus stream: a main instance (FRAME_LEN=8,
// CNT_W=5) and a narrow-counter instance (FRAME_LEN=8, CNT_W=2) used to
// exercise hit-count saturation. Back-to-back frames come from a table.
// Their expected reports are queued as the last bit is driven and compared
// when the report transfers. Hand-written sequences cover gaps, overflow,
// same-cycle transfer/load and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_seq_frame_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid;
    logic       detected;
    logic [1:0] mode;
    logic       rep_ready;

    logic       rep_valid;
    logic [4:0] rep_hits;
    logic [3:0] rep_first_idx;
    logic       rep_any;
    logic [1:0] rep_mode;
    logic       overflow;
    logic [7:0] drop_cnt;

    logic       s_rep_valid;
    logic [1:0] s_rep_hits;
    logic [3:0] s_rep_first_idx;
    logic       s_rep_any;
    logic [1:0] s_rep_mode;
    logic       s_overflow;
    logic [7:0] s_drop_cnt;

    seq_frame_monitor #(.FRAME_LEN(8), .CNT_W(5), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .detected(detected),
        .mode(mode), .rep_ready(rep_ready), .rep_valid(rep_valid),
        .rep_hits(rep_hits), .rep_first_idx(rep_first_idx), .rep_any(rep_any),
        .rep_mode(rep_mode), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    seq_frame_monitor #(.FRAME_LEN(8), .CNT_W(2), .IDX_W(4)) dut_sat (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .detected(detected),
        .mode(mode), .rep_ready(rep_ready), .rep_valid(s_rep_valid),
        .rep_hits(s_rep_hits), .rep_first_idx(s_rep_first_idx), .rep_any(s_rep_any),
        .rep_mode(s_rep_mode), .overflow(s_overflow), .drop_cnt(s_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] det;      // det[i] = detected at frame position i
        logic [1:0] mode;     // mode at bit 0 (inverted on the other bits)
        int         hits;
        int         first;
        int         any;
        int         hits_sat; // expected hits for the CNT_W=2 instance
    } vec_t;

    typedef struct {
        int hits;
        int first;
        int any;
        int mode;
        int hits_sat;
    } exp_t;

    vec_t tbl[5];
    exp_t sb_q[$];

    int   checks   = 0;
    int   failures = 0;
    bit   sb_en    = 1'b0;
    bit   vchk_en  = 1'b0;
    logic vchk_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle. Outputs are observed on the falling edge; a report
    // with rep_valid && rep_ready there transfers on the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb_en) begin
            if (vchk_en) chk("valid_timing", {31'd0, rep_valid}, {31'd0, vchk_exp});
            if (rep_valid && rep_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_report: got hits=%0d with empty queue, required no report", rep_hits);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_hits", 32'(rep_hits), e.hits);
                    chk("sb_first_idx", 32'(rep_first_idx), e.first);
                    chk("sb_any", 32'(rep_any), e.any);
                    chk("sb_mode", 32'(rep_mode), e.mode);
                    chk("sb_hits_sat", 32'(s_rep_hits), e.hits_sat);
                    chk("sb_first_idx_sat", 32'(s_rep_first_idx), e.first);
                    $display("report: hits=%0d first=%0d any=%0d mode=%0d sat_hits=%0d",
                             rep_hits, rep_first_idx, rep_any, rep_mode, s_rep_hits);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input logic d, input logic [1:0] m, input logic r);
        bit_valid = v;
        detected  = d;
        mode      = m;
        rep_ready = r;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] det, input logic [1:0] m,
                              input logic rdy_other, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, det[i], (i == 0) ? m : ~m, (i == 7) ? rdy_last : rdy_other);
        end
        bit_valid = 1'b0;
        detected  = 1'b0;
        rep_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bit_valid = 1'b0;
        detected  = 1'b0;
        mode      = 2'b00;
        rep_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        tbl[0] = '{det: 8'b0010_0100, mode: 2'd2, hits: 2, first: 2, any: 1, hits_sat: 2};
        tbl[1] = '{det: 8'b0000_0000, mode: 2'd1, hits: 0, first: 0, any: 0, hits_sat: 0};
        tbl[2] = '{det: 8'b1111_1111, mode: 2'd3, hits: 8, first: 0, any: 1, hits_sat: 3};
        tbl[3] = '{det: 8'b1000_0000, mode: 2'd0, hits: 1, first: 7, any: 1, hits_sat: 1};
        tbl[4] = '{det: 8'b0101_0000, mode: 2'd2, hits: 2, first: 4, any: 1, hits_sat: 2};

        // Reset state
        do_reset();
        chk("reset_valid", 32'(rep_valid), 0);
        chk("reset_hits", 32'(rep_hits), 0);
        chk("reset_first_idx", 32'(rep_first_idx), 0);
        chk("reset_any", 32'(rep_any), 0);
        chk("reset_mode", 32'(rep_mode), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_drop_cnt", 32'(drop_cnt), 0);

        // Back-to-back table frames with rep_ready held high
        sb_en   = 1'b1;
        vchk_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 8; i++) begin
                vchk_exp = (i == 0 && f > 0);
                if (i == 7) begin
                    e = '{hits: tbl[f].hits, first: tbl[f].first, any: tbl[f].any,
                          mode: int'(tbl[f].mode), hits_sat: tbl[f].hits_sat};
                    sb_q.push_back(e);
                end
                send_bit(1'b1, tbl[f].det[i], (i == 0) ? tbl[f].mode : ~tbl[f].mode, 1'b1);
            end
        end
        vchk_exp = 1'b1;
        send_bit(1'b0, 1'b1, 2'd0, 1'b1);
        vchk_exp = 1'b0;
        send_bit(1'b0, 1'b0, 2'd0, 1'b1);
        sb_en   = 1'b0;
        vchk_en = 1'b0;
        chk("sb_drained", sb_q.size(), 0);
        chk("table_overflow", 32'(overflow), 0);

        // Gapped frame: no detections on valid bits, detected=1 in the gaps
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 1'b0, (i == 0) ? 2'd1 : 2'd2, 1'b0);
            if (i < 7) begin
                for (int g = 0; g < 3; g++) send_bit(1'b0, 1'b1, 2'd3, 1'b0);
            end
            if (i == 6) chk("gap_no_early_valid", 32'(rep_valid), 0);
        end
        bit_valid = 1'b0;
        detected  = 1'b0;
        $display("gap frame: valid=%0d hits=%0d first=%0d any=%0d mode=%0d",
                 rep_valid, rep_hits, rep_first_idx, rep_any, rep_mode);
        chk("gap_valid", 32'(rep_valid), 1);
        chk("gap_hits", 32'(rep_hits), 0);
        chk("gap_any", 32'(rep_any), 0);
        chk("gap_first_idx", 32'(rep_first_idx), 0);
        chk("gap_mode", 32'(rep_mode), 1);
        send_bit(1'b0, 1'b0, 2'd0, 1'b1);
        chk("gap_drained", 32'(rep_valid), 0);

        // Consumer stalled across three frames
        send_frame(8'b0000_1000, 2'd1, 1'b0, 1'b0);
        $display("stall frame1: valid=%0d hits=%0d first=%0d", rep_valid, rep_hits, rep_first_idx);
        chk("stall1_valid", 32'(rep_valid), 1);
        chk("stall1_hits", 32'(rep_hits), 1);
        chk("stall1_first_idx", 32'(rep_first_idx), 3);
        chk("stall1_overflow", 32'(overflow), 0);
        send_frame(8'b1111_1111, 2'd2, 1'b0, 1'b0);
        $display("stall frame2: hits=%0d overflow=%0d drop=%0d", rep_hits, overflow, drop_cnt);
        chk("stall2_held_hits", 32'(rep_hits), 1);
        chk("stall2_held_first", 32'(rep_first_idx), 3);
        chk("stall2_held_mode", 32'(rep_mode), 1);
        chk("stall2_overflow", 32'(overflow), 1);
        chk("stall2_drop_cnt", 32'(drop_cnt), 1);
        send_frame(8'b0000_0000, 2'd3, 1'b0, 1'b0);
        $display("stall frame3: hits=%0d overflow=%0d drop=%0d", rep_hits, overflow, drop_cnt);
        chk("stall3_drop_cnt", 32'(drop_cnt), 2);
        chk("stall3_held_hits", 32'(rep_hits), 1);
        send_bit(1'b0, 1'b0, 2'd0, 1'b1);
        chk("stall_drained", 32'(rep_valid), 0);
        send_bit(1'b0, 1'b0, 2'd0, 1'b0);
        chk("overflow_sticky", 32'(overflow), 1);
        do_reset();
        chk("overflow_cleared", 32'(overflow), 0);
        chk("drop_cnt_cleared", 32'(drop_cnt), 0);

        // Ready raised exactly in frame 2's completion cycle
        send_frame(8'b0000_0010, 2'd0, 1'b0, 1'b0);
        chk("swap1_first_idx", 32'(rep_first_idx), 1);
        send_frame(8'b0100_0000, 2'd3, 1'b0, 1'b1);
        $display("swap frame2: valid=%0d hits=%0d first=%0d mode=%0d overflow=%0d",
                 rep_valid, rep_hits, rep_first_idx, rep_mode, overflow);
        chk("swap_valid", 32'(rep_valid), 1);
        chk("swap_hits", 32'(rep_hits), 1);
        chk("swap_first_idx", 32'(rep_first_idx), 6);
        chk("swap_mode", 32'(rep_mode), 3);
        chk("swap_overflow", 32'(overflow), 0);
        chk("swap_drop_cnt", 32'(drop_cnt), 0);
        send_bit(1'b0, 1'b0, 2'd0, 1'b1);
        chk("swap_drained", 32'(rep_valid), 0);

        // Reset at pos=4 with a report held
        send_frame(8'b0000_0100, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 2'd2, 1'b0);
        rst = 1'b1;
        send_bit(1'b1, 1'b1, 2'd3, 1'b0);
        rst = 1'b0;
        bit_valid = 1'b0;
        $display("midreset: valid=%0d hits=%0d first=%0d any=%0d mode=%0d",
                 rep_valid, rep_hits, rep_first_idx, rep_any, rep_mode);
        chk("midrst_valid", 32'(rep_valid), 0);
        chk("midrst_hits", 32'(rep_hits), 0);
        chk("midrst_first_idx", 32'(rep_first_idx), 0);
        chk("midrst_any", 32'(rep_any), 0);
        chk("midrst_mode", 32'(rep_mode), 0);
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1, (i == 0 || i == 5), (i == 0) ? 2'd2 : 2'd1, 1'b0);
        end
        chk("postrst_no_early_valid", 32'(rep_valid), 0);
        send_bit(1'b1, 1'b0, 2'd1, 1'b0);
        bit_valid = 1'b0;
        $display("postreset frame: valid=%0d hits=%0d first=%0d any=%0d mode=%0d",
                 rep_valid, rep_hits, rep_first_idx, rep_any, rep_mode);
        chk("postrst_valid", 32'(rep_valid), 1);
        chk("postrst_hits", 32'(rep_hits), 2);
        chk("postrst_first_idx", 32'(rep_first_idx), 0);
        chk("postrst_any", 32'(rep_any), 1);
        chk("postrst_mode", 32'(rep_mode), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
